// File: rtl/adxl362_spi_responder_pkg.sv
// Shared constants, state encoding and payload types for the ADXL362 SPI responder.
// Also holds the command/address constants used by spi_master.
package adxl362_spi_responder_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned SCRATCH_N = 13;
  localparam int unsigned SCR_IDX_W = 4;

  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h0B;
  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h0A;

  localparam logic [ADDR_W-1:0] ADDR_DEVID      = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_DEVID_MST  = 6'h01;
  localparam logic [ADDR_W-1:0] ADDR_PARTID     = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_REVID      = 6'h03;
  localparam logic [ADDR_W-1:0] ADDR_XDATA      = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_YDATA      = 6'h09;
  localparam logic [ADDR_W-1:0] ADDR_ZDATA      = 6'h0A;
  localparam logic [ADDR_W-1:0] ADDR_XDATA_L    = 6'h0E;
  localparam logic [ADDR_W-1:0] ADDR_XDATA_H    = 6'h0F;
  localparam logic [ADDR_W-1:0] ADDR_YDATA_L    = 6'h10;
  localparam logic [ADDR_W-1:0] ADDR_YDATA_H    = 6'h11;
  localparam logic [ADDR_W-1:0] ADDR_ZDATA_L    = 6'h12;
  localparam logic [ADDR_W-1:0] ADDR_ZDATA_H    = 6'h13;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH_LO = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH_HI = 6'h2C;
  localparam logic [ADDR_W-1:0] ADDR_POWER_CTL  = 6'h2D;

  localparam logic [BYTE_W-1:0] DEVID_MST_VAL = 8'h1D;
  localparam logic [BYTE_W-1:0] REVID_VAL     = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_DROP
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] z;
    logic [SAMPLE_W-1:0] y;
    logic [SAMPLE_W-1:0] x;
  } snapshot_t;

  function automatic logic is_scratch(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_SCRATCH_LO) && (a <= ADDR_SCRATCH_HI);
  endfunction

endpackage

// File: rtl/adxl362_spi_responder_spi_in_sync.sv
// N-stage synchronizers for sclk, cs_n and mosi with edge pulses on sclk and cs_n.
// cs_n resets to 0 so a chip select already low at reset release never reads as a fresh fall.
module adxl362_spi_responder_spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise_c,
  output logic sclk_fall_c,
  output logic cs_fall_c,
  output logic cs_rise_c
);

  localparam int unsigned TOP = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_sync_q[TOP];
    cs_prev_d   = cs_sync_q[TOP];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign cs_n_s      = cs_sync_q[TOP];
  assign mosi_s      = mosi_sync_q[TOP];
  assign sclk_rise_c =  sclk_sync_q[TOP] & ~sclk_prev_q;
  assign sclk_fall_c = ~sclk_sync_q[TOP] &  sclk_prev_q;
  assign cs_fall_c   = ~cs_sync_q[TOP]   &  cs_prev_q;
  assign cs_rise_c   =  cs_sync_q[TOP]   & ~cs_prev_q;

endmodule

// File: rtl/adxl362_spi_responder.sv
// ADXL362 SPI target model: decodes read/write commands and serves a small register map.
// Everything runs on clk; sclk is only sampled through the synchronizer.
module adxl362_spi_responder
  import adxl362_spi_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  input  logic [SAMPLE_W-1:0] x_sample,
  input  logic [SAMPLE_W-1:0] y_sample,
  input  logic [SAMPLE_W-1:0] z_sample,
  output logic [BYTE_W-1:0]   power_ctl,
  output logic                measure_en,
  output logic                wr_strobe,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [BYTE_W-1:0]   wr_data
);

  logic cs_n_s, mosi_s, sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;

  adxl362_spi_responder_spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .cs_n_s     (cs_n_s),
    .mosi_s     (mosi_s),
    .sclk_rise_c(sclk_rise_c),
    .sclk_fall_c(sclk_fall_c),
    .cs_fall_c  (cs_fall_c),
    .cs_rise_c  (cs_rise_c)
  );

  state_e                          state_q, state_d;
  logic                            dir_rd_q, dir_rd_d;
  logic [BIT_CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0]               shift_q, shift_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [BYTE_W-1:0]               tx_shift_q, tx_shift_d;
  logic                            miso_q, miso_d;
  snapshot_t                       snap_q, snap_d;
  logic [SCRATCH_N-1:0][BYTE_W-1:0] scratch_q, scratch_d;
  logic [BYTE_W-1:0]               power_ctl_q, power_ctl_d;
  logic                            measure_en_q, measure_en_d;
  logic                            wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]               wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]               wr_data_q, wr_data_d;

  logic                 byte_done_c;
  logic [BYTE_W-1:0]    rx_byte_c;
  logic [ADDR_W-1:0]    rd_addr_c;
  logic [BYTE_W-1:0]    rd_data_c;
  logic [SCR_IDX_W-1:0] rd_idx_c;
  logic [SCR_IDX_W-1:0] wr_idx_c;

  // cs_n high masks byte_done, so a coincident cs_n rise always wins over a write
  assign byte_done_c = sclk_rise_c && !cs_n_s && (bit_cnt_q == BIT_CNT_W'(7));
  assign rx_byte_c   = {shift_q, mosi_s};
  assign rd_addr_c   = (state_q == ST_ADDR) ? rx_byte_c[ADDR_W-1:0] : ADDR_W'(addr_q + ADDR_W'(1));
  assign rd_idx_c    = SCR_IDX_W'(rd_addr_c - ADDR_SCRATCH_LO);
  assign wr_idx_c    = SCR_IDX_W'(addr_q - ADDR_SCRATCH_LO);

  // Register map read mux; one port serves both the first and the next burst byte
  always_comb begin
    rd_data_c = '0;
    case (rd_addr_c)
      ADDR_DEVID:     rd_data_c = DEVID_AD;
      ADDR_DEVID_MST: rd_data_c = DEVID_MST_VAL;
      ADDR_PARTID:    rd_data_c = PARTID;
      ADDR_REVID:     rd_data_c = REVID_VAL;
      ADDR_XDATA:     rd_data_c = snap_q.x[11:4];
      ADDR_YDATA:     rd_data_c = snap_q.y[11:4];
      ADDR_ZDATA:     rd_data_c = snap_q.z[11:4];
      ADDR_XDATA_L:   rd_data_c = snap_q.x[7:0];
      ADDR_XDATA_H:   rd_data_c = snap_q.x[15:8];
      ADDR_YDATA_L:   rd_data_c = snap_q.y[7:0];
      ADDR_YDATA_H:   rd_data_c = snap_q.y[15:8];
      ADDR_ZDATA_L:   rd_data_c = snap_q.z[7:0];
      ADDR_ZDATA_H:   rd_data_c = snap_q.z[15:8];
      ADDR_POWER_CTL: rd_data_c = power_ctl_q;
      default: begin
        if (is_scratch(rd_addr_c)) rd_data_c = scratch_q[rd_idx_c];
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_rd_d    = dir_rd_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    snap_d      = snap_q;
    scratch_d   = scratch_q;
    power_ctl_d = power_ctl_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (cs_n_s) begin
      bit_cnt_d = '0;
    end else if (sclk_rise_c) begin
      bit_cnt_d = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
      shift_d   = {shift_q[BYTE_W-3:0], mosi_s};
    end

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall_c) begin
          state_d = ST_CMD;
          snap_d.x = x_sample;
          snap_d.y = y_sample;
          snap_d.z = z_sample;
        end
      end
      ST_CMD: begin
        miso_d = 1'b0;
        if (byte_done_c) begin
          if (rx_byte_c == CMD_READ) begin
            state_d  = ST_ADDR;
            dir_rd_d = 1'b1;
          end else if (rx_byte_c == CMD_WRITE) begin
            state_d  = ST_ADDR;
            dir_rd_d = 1'b0;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_ADDR: begin
        miso_d = 1'b0;
        if (byte_done_c) begin
          addr_d = rx_byte_c[ADDR_W-1:0];
          if (dir_rd_q) begin
            state_d    = ST_RD;
            tx_shift_d = rd_data_c;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_RD: begin
        if (sclk_fall_c) begin
          miso_d     = tx_shift_q[BYTE_W-1];
          tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
        end
        if (byte_done_c) begin
          addr_d     = ADDR_W'(addr_q + ADDR_W'(1));
          tx_shift_d = rd_data_c;
        end
      end
      ST_WR: begin
        miso_d = 1'b0;
        // Strobe fires for read-only addresses too; only the storage update is skipped
        if (byte_done_c) begin
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = rx_byte_c;
          if (is_scratch(addr_q)) scratch_d[wr_idx_c] = rx_byte_c;
          else if (addr_q == ADDR_POWER_CTL) power_ctl_d = rx_byte_c;
          addr_d = ADDR_W'(addr_q + ADDR_W'(1));
        end
      end
      ST_DROP: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    if (cs_rise_c) begin
      state_d = ST_IDLE;
      miso_d  = 1'b0;
    end

    measure_en_d = (power_ctl_d[1:0] == 2'b10);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dir_rd_q     <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      tx_shift_q   <= '0;
      miso_q       <= 1'b0;
      snap_q       <= '0;
      scratch_q    <= '0;
      power_ctl_q  <= '0;
      measure_en_q <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      dir_rd_q     <= dir_rd_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      tx_shift_q   <= tx_shift_d;
      miso_q       <= miso_d;
      snap_q       <= snap_d;
      scratch_q    <= scratch_d;
      power_ctl_q  <= power_ctl_d;
      measure_en_q <= measure_en_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign miso       = miso_q;
  assign power_ctl  = power_ctl_q;
  assign measure_en = measure_en_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Bench for adxl362_spi_responder: directed register-map cases plus random SPI transactions
// checked against a transaction-level register model.
module tb_adxl362_spi_responder;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] x_sample = 16'h0;
  logic [15:0] y_sample = 16'h0;
  logic [15:0] z_sample = 16'h0;
  logic [7:0]  power_ctl;
  logic        measure_en;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  adxl362_spi_responder dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .x_sample  (x_sample),
    .y_sample  (y_sample),
    .z_sample  (z_sample),
    .power_ctl (power_ctl),
    .measure_en(measure_en),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_scratch [13];
  logic [7:0]  m_pctl = 8'h00;
  logic [15:0] m_x, m_y, m_z;
  logic [13:0] exp_wr [$];

  logic [7:0]  txb [8];
  logic [7:0]  rxb [8];
  int          idle_cnt = 0;
  int          strobe_cnt = 0;
  logic [5:0]  last_wa = '0;
  logic [7:0]  last_wd = '0;
  logic [13:0] mon_w;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_reg(input logic [5:0] a);
    if (a >= 6'h20 && a <= 6'h2C) return m_scratch[int'(a) - 32];
    case (a)
      6'h00: return 8'hAD;
      6'h01: return 8'h1D;
      6'h02: return 8'hF2;
      6'h03: return 8'h02;
      6'h08: return m_x[11:4];
      6'h09: return m_y[11:4];
      6'h0A: return m_z[11:4];
      6'h0E: return m_x[7:0];
      6'h0F: return m_x[15:8];
      6'h10: return m_y[7:0];
      6'h11: return m_y[15:8];
      6'h12: return m_z[7:0];
      6'h13: return m_z[15:8];
      6'h2D: return m_pctl;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 13; i++) m_scratch[i] = 8'h00;
    m_pctl = 8'h00;
    exp_wr.delete();
  endtask

  // Mode 0 master: drive mosi while sclk low, sample miso at the rising edge
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (H) @(posedge clk);
      #1;
      sclk = 1'b1;
      rx[7-i] = miso;
      repeat (H) @(posedge clk);
      #1;
      sclk = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [5:0] addr, input int nbytes,
                         input int abort_bits, input int mid_after, input logic [15:0] mid_x);
    logic [7:0] r, e;
    logic [5:0] a;
    bit is_rd, is_wr;
    is_rd = (cmd == 8'h0B);
    is_wr = (cmd == 8'h0A);
    m_x = x_sample;
    m_y = y_sample;
    m_z = z_sample;
    for (int i = 0; i < 8; i++) rxb[i] = 8'h00;
    cs_n = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    spi_byte(cmd, 8, r);
    chk("cmd_phase_miso", r, 8'h00);
    spi_byte({2'($urandom), addr}, 8, r);
    chk("addr_phase_miso", r, 8'h00);
    a = addr;
    for (int i = 0; i < nbytes; i++) begin
      if (is_wr) begin
        exp_wr.push_back({a, txb[i]});
        if (a >= 6'h20 && a <= 6'h2C) m_scratch[int'(a) - 32] = txb[i];
        else if (a == 6'h2D) m_pctl = txb[i];
      end
      e = is_rd ? model_reg(a) : 8'h00;
      spi_byte(txb[i], 8, r);
      rxb[i] = r;
      chk($sformatf("data_byte%0d_a%02h", i, a), r, e);
      if (i == mid_after) x_sample = mid_x;
      a = a + 6'd1;
    end
    if (abort_bits > 0) spi_byte(8'($urandom), abort_bits, r);
    repeat (H) @(posedge clk);
    #1;
    cs_n = 1'b1;
    repeat (4 * H) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) idle_cnt <= cs_n ? idle_cnt + 1 : 0;

  // Continuous compare: every write strobe against the expected-write queue, idle outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe) begin
        strobe_cnt = strobe_cnt + 1;
        last_wa = wr_addr;
        last_wd = wr_data;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_strobe_unexpected: got addr %h data %h required no strobe", wr_addr, wr_data);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", 16'(wr_addr), 16'(mon_w[13:8]));
          chk("wr_data", 16'(wr_data), 16'(mon_w[7:0]));
        end
      end
      if (cs_n && idle_cnt > 6) begin
        chk("idle_miso", 16'(miso), 16'h0);
        chk("idle_power_ctl", 16'(power_ctl), 16'(m_pctl));
        chk("idle_measure_en", 16'(measure_en), 16'(m_pctl[1:0] == 2'b10));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, 16'(miso), 16'h0);
    chk({tag, "_power_ctl"}, 16'(power_ctl), 16'h0);
    chk({tag, "_measure_en"}, 16'(measure_en), 16'h0);
    chk({tag, "_wr_strobe"}, 16'(wr_strobe), 16'h0);
    chk({tag, "_wr_addr"}, 16'(wr_addr), 16'h0);
    chk({tag, "_wr_data"}, 16'(wr_data), 16'h0);
  endtask

  initial begin
    int s0, sel, nb, ab;
    logic [7:0] cmd, r;
    logic [5:0] ad;
    model_reset();
    for (int i = 0; i < 8; i++) txb[i] = 8'h00;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4 * H) @(posedge clk);
    #1;

    // Device ID registers
    run_txn(8'h0B, 6'h00, 1, 0, -1, 16'h0);
    chk("devid", rxb[0], 8'hAD);
    run_txn(8'h0B, 6'h02, 1, 0, -1, 16'h0);
    chk("partid", rxb[0], 8'hF2);

    // Burst read across X/Y sample bytes
    x_sample = 16'h0123;
    y_sample = 16'hFF9C;
    run_txn(8'h0B, 6'h0E, 4, 0, -1, 16'h0);
    chk("burst_xl", rxb[0], 8'h23);
    chk("burst_xh", rxb[1], 8'h01);
    chk("burst_yl", rxb[2], 8'h9C);
    chk("burst_yh", rxb[3], 8'hFF);

    // Snapshot holds the value captured at chip select
    x_sample = 16'h00FF;
    run_txn(8'h0B, 6'h0E, 2, 0, 0, 16'h0100);
    chk("snap_old_l", rxb[0], 8'hFF);
    chk("snap_old_h", rxb[1], 8'h00);
    run_txn(8'h0B, 6'h0E, 2, 0, -1, 16'h0);
    chk("snap_new_l", rxb[0], 8'h00);
    chk("snap_new_h", rxb[1], 8'h01);

    // POWER_CTL write and read back
    s0 = strobe_cnt;
    txb[0] = 8'h02;
    run_txn(8'h0A, 6'h2D, 1, 0, -1, 16'h0);
    chk("pctl_value", 16'(power_ctl), 16'h0002);
    chk("pctl_measure_en", 16'(measure_en), 16'h1);
    chk("pctl_strobe_count", 16'(strobe_cnt - s0), 16'h1);
    chk("pctl_strobe_addr", 16'(last_wa), 16'h002D);
    chk("pctl_strobe_data", 16'(last_wd), 16'h0002);
    run_txn(8'h0B, 6'h2D, 1, 0, -1, 16'h0);
    chk("pctl_readback", rxb[0], 8'h02);

    // Aborted write byte
    s0 = strobe_cnt;
    run_txn(8'h0A, 6'h2D, 0, 5, -1, 16'h0);
    chk("abort_strobe_count", 16'(strobe_cnt - s0), 16'h0);
    chk("abort_pctl", 16'(power_ctl), 16'h0002);
    run_txn(8'h0B, 6'h00, 1, 0, -1, 16'h0);
    chk("abort_next_devid", rxb[0], 8'hAD);

    // Address wrap and an unknown command
    run_txn(8'h0B, 6'h3F, 3, 0, -1, 16'h0);
    chk("wrap_3f", rxb[0], 8'h00);
    chk("wrap_00", rxb[1], 8'hAD);
    chk("wrap_01", rxb[2], 8'h1D);
    s0 = strobe_cnt;
    for (int i = 0; i < 8; i++) txb[i] = 8'($urandom);
    run_txn(8'h55, 6'h2D, 2, 0, -1, 16'h0);
    chk("badcmd_byte0", rxb[0], 8'h00);
    chk("badcmd_byte1", rxb[1], 8'h00);
    chk("badcmd_strobe_count", 16'(strobe_cnt - s0), 16'h0);

    // Reset in the middle of a burst read
    txb[0] = 8'h5A;
    run_txn(8'h0A, 6'h20, 1, 0, -1, 16'h0);
    cs_n = 1'b0;
    repeat (H) @(posedge clk);
    #1;
    spi_byte(8'h0B, 8, r);
    spi_byte(8'h00, 8, r);
    spi_byte(8'h00, 4, r);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    spi_byte(8'h0B, 8, r);
    chk("post_rst_no_txn_miso", r, 8'h00);
    spi_byte(8'h00, 8, r);
    chk("post_rst_no_txn_miso2", r, 8'h00);
    repeat (H) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (4 * H) @(posedge clk);
    #1;
    run_txn(8'h0B, 6'h20, 1, 0, -1, 16'h0);
    chk("post_rst_scratch", rxb[0], 8'h00);
    run_txn(8'h0B, 6'h00, 1, 0, -1, 16'h0);
    chk("post_rst_devid", rxb[0], 8'hAD);

    // Random transactions against the model
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) cmd = 8'h0B;
      else if (sel < 9) cmd = 8'h0A;
      else cmd = 8'($urandom_range(8'h0C, 8'hFF));
      ad = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(6'h1C, 6'h2F)) : 6'($urandom);
      nb = $urandom_range(0, 4);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      x_sample = 16'($urandom);
      y_sample = 16'($urandom);
      z_sample = 16'($urandom);
      for (int i = 0; i < 8; i++) txb[i] = 8'($urandom);
      run_txn(cmd, ad, nb, ab, -1, 16'h0);
    end

    chk("pending_writes", 16'(exp_wr.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got no completion required finish");
    $fatal(1, "timeout");
  end

endmodule
